lfsr_rand_server: RTL

//   Sequencer/arbiter that shares one external LFSR instance among NUM_REQ requesters.
//   - Loads the LFSR seed after reset and on demand.
//   - Grants requesters round-robin, then steps the LFSR STEPS times per draw.
//   - Returns the resulting word to the granted requester with a one-cycle valid pulse.
//   - Sits between game/test-pattern logic and the LFSR; it is the only driver of the LFSR controls.

---
 rtl/lfsr_rand_server.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_rand_server.sv
// ---------------------------------------------------------------------------
// lfsr_rand_server
//
// Shares one external LFSR among NUM_REQ requesters. After reset, and again
// whenever a reseed has been requested, the block loads the seed into the
// LFSR. When requests are present it grants one requester in round-robin
// order. It then steps the LFSR STEPS times and hands the resulting word to
// that requester with a one-cycle valid pulse. This block is the only driver
// of the LFSR control inputs.
//
// Parameters
//   NUM_BITS : LFSR width, must match the attached LFSR (3..32)
//   NUM_REQ  : number of requesters (2..8)
//   STEPS    : LFSR shifts per draw (>= 1)
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          asynchronous active-low reset
//   i_seed         seed value, sampled while in INIT
//   i_reseed       one-cycle pulse, reload the seed at the next idle point
//   i_req          request vector, each bit held until its grant
//   o_gnt          one-hot grant, non-zero only while o_valid=1
//   o_valid        one-cycle pulse, o_data is valid for the o_gnt requester
//   o_data         LFSR word while o_valid=1, else 0
//   o_busy         0 only in IDLE
//   o_wraps        saturating count of LFSR period completions since seed load
//   o_lfsr_rst     LFSR synchronous active-low reset (0 = load seed)
//   o_lfsr_enable  LFSR shift enable
//   o_lfsr_seed    LFSR seed input
//   i_lfsr_data    LFSR current value
//   i_lfsr_done    LFSR current value equals its seed
// ---------------------------------------------------------------------------
module lfsr_rand_server #(
  parameter int NUM_BITS = 8,
  parameter int NUM_REQ  = 4,
  parameter int STEPS    = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_BITS-1:0] i_seed,
  input  logic                i_reseed,
  input  logic [NUM_REQ-1:0]  i_req,
  output logic [NUM_REQ-1:0]  o_gnt,
  output logic                o_valid,
  output logic [NUM_BITS-1:0] o_data,
  output logic                o_busy,
  output logic [7:0]          o_wraps,
  output logic                o_lfsr_rst,
  output logic                o_lfsr_enable,
  output logic [NUM_BITS-1:0] o_lfsr_seed,
  input  logic [NUM_BITS-1:0] i_lfsr_data,
  input  logic                i_lfsr_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_IDLE    = 2'd1,
    S_STEP    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_rr;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pending;
  logic [7:0]          r_wraps;
  logic [NUM_BITS-1:0] r_seed;

  logic                w_reseed_now;
  logic                w_start_draw;
  logic                w_step_last;
  logic                w_wrap_sample;
  logic [IDX_W-1:0]    w_pick;
  logic [NUM_REQ-1:0]  w_gnt_onehot;

  // Saturating increment for the wrap counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  // Index following idx, wrapping NUM_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // First asserted request at or after ptr, scanning upward with wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
    return pick;
  endfunction

  // A reseed pulse arriving in the same IDLE cycle is acted on at once, so
  // it never leaves a stale pending flag behind.
  assign w_reseed_now  = (r_state == S_IDLE) && (r_pending || i_reseed);
  assign w_start_draw  = (r_state == S_IDLE) && !(r_pending || i_reseed) && (|i_req);
  assign w_step_last   = (r_cnt == LAST_STEP);
  assign w_pick        = rr_pick(i_req, r_rr);
  assign w_gnt_onehot  = NUM_REQ'(1) << r_idx;

  // The first STEP cycle still shows the value left by the previous draw, so
  // it is skipped; DELIVER shows the value after the final shift.
  assign w_wrap_sample = ((r_state == S_STEP) && (r_cnt != '0)) ||
                         (r_state == S_DELIVER);

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:    w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_reseed_now)      w_state_nxt = S_INIT;
        else if (w_start_draw) w_state_nxt = S_STEP;
      end
      S_STEP: begin
        if (w_step_last) w_state_nxt = S_DELIVER;
      end
      S_DELIVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_INIT;
    endcase
  end

  // ---- outputs decoded from the current state ----
  always_comb begin
    o_valid       = 1'b0;
    o_gnt         = '0;
    o_data        = '0;
    o_lfsr_rst    = 1'b1;
    o_lfsr_enable = 1'b0;
    o_busy        = 1'b1;
    // In INIT the LFSR loads on the same edge that latches r_seed, so the
    // live seed is forwarded to keep both copies identical.
    o_lfsr_seed   = r_seed;
    case (r_state)
      S_INIT: begin
        o_lfsr_rst  = 1'b0;
        o_lfsr_seed = i_seed;
      end
      S_IDLE: begin
        o_busy = 1'b0;
      end
      S_STEP: begin
        o_lfsr_enable = 1'b1;
      end
      S_DELIVER: begin
        o_valid = 1'b1;
        o_gnt   = w_gnt_onehot;
        o_data  = i_lfsr_data;
      end
      default: begin
        o_lfsr_rst = 1'b0;
      end
    endcase
  end

  assign o_wraps = r_wraps;

  // ---- state register ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  // ---- reseed request, held until consumed in IDLE ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)            r_pending <= 1'b0;
    else if (w_reseed_now) r_pending <= 1'b0;
    else if (i_reseed)     r_pending <= 1'b1;
  end

  // ---- seed latch ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                 r_seed <= '0;
    else if (r_state == S_INIT) r_seed <= i_seed;
  end

  // ---- arbitration: grant index and round-robin pointer ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_idx <= '0;
      r_rr  <= '0;
    end else begin
      if (w_start_draw)              r_idx <= w_pick;
      if (r_state == S_DELIVER)      r_rr  <= next_idx(r_idx);
    end
  end

  // ---- step counter ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (w_start_draw) begin
      r_cnt <= '0;
    end else if (r_state == S_STEP) begin
      r_cnt <= w_step_last ? '0 : r_cnt + 1'b1;
    end
  end

  // ---- wrap counter, cleared on every seed load ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wraps <= 8'd0;
    end else if (r_state == S_INIT) begin
      r_wraps <= 8'd0;
    end else if (w_wrap_sample && i_lfsr_done) begin
      r_wraps <= sat_inc8(r_wraps);
    end
  end

endmodule
